// File: rtl/sum3_window_accum_pkg.sv
// rtl/sum3_window_accum_pkg.sv - shared constants, state encoding and width check
package sum3_window_accum_pkg;

    localparam int DATA_W = 16;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_FILLING = 1'b1
    } state_t;

    // Legal window size and an accumulator wide enough that WIN full-scale samples cannot overflow
    function automatic bit acc_w_ok(input int log2_win, input int acc_w);
        return (log2_win >= 1) && (log2_win <= 8) && (acc_w >= DATA_W + log2_win);
    endfunction

endpackage

// File: rtl/sum3_window_accum_if.sv
// rtl/sum3_window_accum_if.sv - sample input and window result bundle
interface sum3_window_accum_if
    import sum3_window_accum_pkg::*;
#(
    parameter int LOG2_WIN = 2,
    parameter int ACC_W    = 16 + LOG2_WIN
);
    logic                  in_valid;
    logic [DATA_W-1:0]     sum_in;
    logic                  flush;
    logic                  out_valid;
    logic [ACC_W-1:0]      acc_out;
    logic [DATA_W-1:0]     avg_out;
    logic [LOG2_WIN:0]     count_out;

    modport master (
        output in_valid, sum_in, flush,
        input  out_valid, acc_out, avg_out, count_out
    );

    modport slave (
        input  in_valid, sum_in, flush,
        output out_valid, acc_out, avg_out, count_out
    );
endinterface

// File: rtl/addripple_n.sv
// rtl/addripple_n.sv - parameterised ripple-carry adder, carry-out discarded
module addripple_n #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    logic carry;

    // Bit-serial carry chain from LSB to MSB
    always_comb begin
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end
endmodule

// File: rtl/sum3_window_accum.sv
// rtl/sum3_window_accum.sv - windowed accumulator emitting total, average and count
module sum3_window_accum
    import sum3_window_accum_pkg::*;
#(
    parameter int LOG2_WIN = 2,
    parameter int ACC_W    = 16 + LOG2_WIN
) (
    input  logic              clk,
    input  logic              rst,
    sum3_window_accum_if.slave bus
);
    localparam int CNT_W = LOG2_WIN + 1;
    localparam int WIN   = 1 << LOG2_WIN;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

    if (!acc_w_ok(LOG2_WIN, ACC_W)) begin : g_param_err
        $error("sum3_window_accum: LOG2_WIN must be 1..8 and ACC_W >= 16+LOG2_WIN");
    end

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  acc_out_q, acc_out_d;
    logic [DATA_W-1:0] avg_out_q, avg_out_d;
    logic [CNT_W-1:0]  count_out_q, count_out_d;

    logic [ACC_W-1:0]  sample_ext;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  cnt_inc;
    logic              last_sample;
    logic              non_zero;
    logic              close_win;

    // Idle cycles contribute zero so the adder output is always the running total including this cycle
    always_comb begin
        sample_ext = '0;
        if (bus.in_valid) begin
            sample_ext[DATA_W-1:0] = bus.sum_in;
        end
    end

    addripple_n #(.WIDTH(ACC_W)) u_acc_add (
        .a   (acc_q),
        .b   (sample_ext),
        .sum (acc_sum)
    );

    // Window closes on the final sample, or on flush when anything is held or arriving now
    always_comb begin
        cnt_inc     = cnt_q + CNT_W'(bus.in_valid);
        last_sample = bus.in_valid && (cnt_q == CNT_LAST);
        non_zero    = (state_q == ST_FILLING) || bus.in_valid;
        close_win   = last_sample || (bus.flush && non_zero);
    end

    // Next-state: accumulate, or emit and restart; results hold otherwise
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        out_valid_d = 1'b0;
        acc_out_d   = acc_out_q;
        avg_out_d   = avg_out_q;
        count_out_d = count_out_q;
        if (close_win) begin
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = ST_EMPTY;
            out_valid_d = 1'b1;
            acc_out_d   = acc_sum;
            avg_out_d   = acc_sum[LOG2_WIN +: DATA_W];
            count_out_d = cnt_inc;
        end else if (bus.in_valid) begin
            acc_d   = acc_sum;
            cnt_d   = cnt_inc;
            state_d = ST_FILLING;
        end
    end

    // State and result registers; reset discards any partial window
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            avg_out_q   <= '0;
            count_out_q <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            acc_out_q   <= acc_out_d;
            avg_out_q   <= avg_out_d;
            count_out_q <= count_out_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.avg_out   = avg_out_q;
    assign bus.count_out = count_out_q;
endmodule
